// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the parametrised up/down counter
// and its enable prescaler.
package cnt_pkg;

    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: TICK fires on every DIV-th enabled edge.
// CLR restarts the count; EN low freezes it.
module tick_prescaler
    import cnt_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    generate
        if (DIV <= 1) begin : g_direct
            logic unused_ok;
            assign unused_ok = ^{CLK, RST, CLR};
            assign TICK      = EN;
        end else begin : g_count
            localparam int unsigned   CW   = clog2(DIV);
            localparam logic [CW-1:0] LAST = CW'(DIV - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (CLR) begin
                    cnt_d = '0;
                end else if (EN) begin
                    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign TICK = EN && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/counter_nbit_updown.sv
// Parametrised up/down modulo counter with parallel load, wrap or
// saturate at the range ends, boundary pulses and enable prescaler.
module counter_nbit_updown
    import cnt_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int unsigned     SATURATE = 0,
    parameter int unsigned     DIV      = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF,
    output logic             UNF
);

    generate
        if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
            MODULUS > (64'd1 << WIDTH) || DIV < 1 || DIV > 65536) begin : g_bad_params
            $error("counter_nbit_updown: illegal WIDTH/MODULUS/DIV combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic             step;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .CLR  (LD),
        .TICK (step)
    );

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (LD) begin
            q_d = (D > MAX_Q) ? MAX_Q : D;
        end else if (step) begin
            if (UP == DIR_UP) begin
                if (q_q == MAX_Q) begin
                    ovf_d = 1'b1;
                    q_d   = (SATURATE == CNT_SAT) ? q_q : '0;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (q_q == '0) begin
                    unf_d = 1'b1;
                    q_d   = (SATURATE == CNT_SAT) ? q_q : MAX_Q;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign Q   = q_q;
    assign OVF = ovf_q;
    assign UNF = unf_q;
    assign TC  = (UP == DIR_UP) ? (q_q == MAX_Q) : (q_q == '0);

endmodule
